irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt consumer for the pComputer MMIO bus. Collects irq pulses and levels from
//  peripheral sources (timer, uart, ...) and latches them as pending. Masks them and
//  presents a single irq_out to the CPU. The CPU claims and completes via MMIO registers.
//  Sits between the peripheral irq outputs and the core's external-interrupt input.
// PARAMETERS
//  NSRC  8  number of source lines, 1..31; source i reports claim ID i+1 (ID 0 = none)
// PORTS
//  clk      in   1     system clock; all state updates on posedge
//  rst      in   1     reset, asynchronous, active-high
//  a        in   3     register word select
//  d        in   32    write data, byte-swapped: field = {d[7:0],d[15:8],d[23:16],d[31:24]}
//  we       in   1     write strobe, one cycle per access
//  spo      out  32    read data, combinational from a; same byte swap as d; unmapped -> 0
//  src_irq  in   NSRC  source request lines; pulse or level
//  irq_out  out  1     registered interrupt request to CPU
// BEHAVIOUR
//  Register map (field values shown before byte swap):
//   000 PENDING RO: pending[NSRC-1:0]
//   001 ENABLE  RW: enable[NSRC-1:0]
//   010 CLAIM   R: best ID; W: claim ID
//   011 COMPLETE W: ID
//   100 MODE    RW: 1 = level, 0 = rising edge, per source
//   101 STATUS  RO: {in_svc_id[7:0], 7'b0, state}
//  Reset: pending, enable, mode, src_q, in_svc_id = 0; state = IDLE; irq_out = 0.
//  Detect: src_q <= src_irq every cycle. Edge source: set = src_irq & ~src_q.
//   Level source: set = src_irq.
//  Latency: a source high before edge k sets pending at edge k; irq_out rises at edge k+1.
//  Best ID: lowest index i with pending[i] & enable[i], reported as i+1; 0 if none.
//  FSM, 1 bit:
//   IDLE:  irq_out <= (best != 0). A write to CLAIM with field == best (nonzero)
//          clears pending[best-1], sets in_svc_id = best, goes to SERVICE, and drives
//          irq_out <= 0. A CLAIM write with a non-matching field is ignored.
//   SERVICE: irq_out <= 0; no nesting. A write to COMPLETE with field == in_svc_id
//          sets in_svc_id = 0 and returns to IDLE. Any other COMPLETE value is ignored.
//          A CLAIM write in this state is ignored.
//  Collisions:
//   - A new set on the same edge as a claim-clear of that bit: set wins, pending stays 1.
//   - Level source still high after claim: re-pends next edge. Software masks or clears
//     the device.
//   - Clearing an enable bit: pending is kept; irq_out drops on the next edge if best
//     becomes 0.
//   - Writes to RO or unmapped offsets have no effect. Only bits [NSRC-1:0] are stored;
//     upper field bits are ignored.
//   - rst asserted mid-SERVICE: immediately IDLE, all registers cleared, irq_out = 0.
//  Reads have no side effects (spo is combinational).
// STRUCTURE
//  quasi.vh: `define IRQC_PENDING/ENABLE/CLAIM/COMPLETE/MODE/STATUS offsets,
//   `define IRQC_IDLE 1'b0, `define IRQC_SERVICE 1'b1, and a byte-swap macro shared with
//   other MMIO blocks.
//  Sub-module irq_prio_enc: NSRC-wide lowest-index-first encoder -> ID (0 = none).
//  Top holds the edge detect, registers, FSM and read mux.
// TESTING
//  1. Write ENABLE d=32'h01000000 (field 1). Pulse src_irq[0] for 1 cycle before edge k.
//     -> PENDING=1 at k; irq_out=1 after k+1; CLAIM reads field 1.
//  2. Write CLAIM d=32'h01000000, then COMPLETE d=32'h01000000.
//     -> irq_out=0 from the claim edge; STATUS state=SERVICE, then IDLE; PENDING=0.
//  3. Enable all sources. Pend sources 2 and 5 in the same cycle.
//     -> CLAIM=3. After claim+complete, CLAIM=6. Then CLAIM=0 and irq_out=0.
//  4. Source 0 in edge mode: pulse it on the same edge as its CLAIM write.
//     -> PENDING[0] stays 1. After COMPLETE, irq_out reasserts.
//  5. MODE bit 1 = 1, src_irq[1] held high. Claim, then complete with ID 5.
//     -> the wrong complete is ignored and the state stays SERVICE. After the correct
//     complete, irq_out returns, because the level re-pended.
//  6. Assert rst asynchronously while in SERVICE with PENDING nonzero.
//     -> all registers 0 and irq_out=0 without waiting for a clock edge. After release,
//     pulse a source -> irq_out follows the test-1 timing.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states,
// claim-ID width and the MMIO byte-swap helper.
package irq_ctrl_pkg;

  localparam int ID_W = 8;

  localparam logic [2:0] IRQC_PENDING  = 3'd0;
  localparam logic [2:0] IRQC_ENABLE   = 3'd1;
  localparam logic [2:0] IRQC_CLAIM    = 3'd2;
  localparam logic [2:0] IRQC_COMPLETE = 3'd3;
  localparam logic [2:0] IRQC_MODE     = 3'd4;
  localparam logic [2:0] IRQC_STATUS   = 3'd5;

  typedef enum logic {
    IRQC_IDLE    = 1'b0,
    IRQC_SERVICE = 1'b1
  } irqc_state_e;

  // The MMIO bus presents register fields with byte order reversed.
  function automatic logic [31:0] byte_swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports index+1 of the lowest set request,
// or 0 when no request is set.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req_i,
  output logic [ID_W-1:0] id_o
);

  always_comb begin
    id_o = '0;
    // Walk downward so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// MMIO interrupt controller: latches edge/level source requests as pending, masks
// them with enable, and runs a claim/complete handshake with the CPU.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  output logic [31:0]     spo,
  input  logic [NSRC-1:0] src_irq,
  output logic            irq_out
);

  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] src_q;
  logic [ID_W-1:0] in_svc_q, in_svc_d;
  irqc_state_e     state_q, state_d;
  logic            irq_q, irq_d;

  logic [31:0]     wr_field;
  logic [31:0]     rd_field;
  logic [ID_W-1:0] best_id;
  logic [NSRC-1:0] set_v;
  logic [NSRC-1:0] clr_v;
  logic            claim_ok;
  logic            complete_ok;

  assign wr_field = byte_swap(d);

  // Level sources set every cycle they are high; edge sources only on a 0->1 step.
  assign set_v = src_irq & (mode_q | ~src_q);

  irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req_i (pending_q & enable_q),
    .id_o  (best_id)
  );

  assign claim_ok    = we && (a == IRQC_CLAIM) && (best_id != '0)
                       && (wr_field == 32'(best_id));
  assign complete_ok = we && (a == IRQC_COMPLETE) && (wr_field == 32'(in_svc_q));

  always_comb begin
    state_d  = state_q;
    in_svc_d = in_svc_q;
    irq_d    = 1'b0;
    clr_v    = '0;
    unique case (state_q)
      IRQC_IDLE: begin
        irq_d = (best_id != '0);
        if (claim_ok) begin
          clr_v    = NSRC'(1) << (best_id - 1'b1);
          in_svc_d = best_id;
          irq_d    = 1'b0;
          state_d  = IRQC_SERVICE;
        end
      end
      IRQC_SERVICE: begin
        if (complete_ok) begin
          in_svc_d = '0;
          state_d  = IRQC_IDLE;
        end
      end
    endcase
  end

  // A fresh set on the claim edge must survive the claim-clear.
  assign pending_d = (pending_q & ~clr_v) | set_v;
  assign enable_d  = (we && a == IRQC_ENABLE) ? wr_field[NSRC-1:0] : enable_q;
  assign mode_d    = (we && a == IRQC_MODE)   ? wr_field[NSRC-1:0] : mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      src_q     <= '0;
      in_svc_q  <= '0;
      state_q   <= IRQC_IDLE;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      src_q     <= src_irq;
      in_svc_q  <= in_svc_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rd_field = '0;
    case (a)
      IRQC_PENDING: rd_field[NSRC-1:0] = pending_q;
      IRQC_ENABLE:  rd_field[NSRC-1:0] = enable_q;
      IRQC_CLAIM:   rd_field[ID_W-1:0] = best_id;
      IRQC_MODE:    rd_field[NSRC-1:0] = mode_q;
      IRQC_STATUS:  rd_field[15:0]     = {in_svc_q, 7'b0, state_q};
      default:      rd_field           = '0;
    endcase
  end

  assign spo     = byte_swap(rd_field);
  assign irq_out = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, claim/complete flow, priority, collisions,
// level re-pend, enable masking and asynchronous reset.
module tb_irq_ctrl;

  localparam int NSRC = 8;
  localparam logic [2:0] R_PEND = 3'd0;
  localparam logic [2:0] R_ENA  = 3'd1;
  localparam logic [2:0] R_CLM  = 3'd2;
  localparam logic [2:0] R_CMP  = 3'd3;
  localparam logic [2:0] R_MOD  = 3'd4;
  localparam logic [2:0] R_STS  = 3'd5;
  localparam logic [2:0] R_UNM  = 3'd7;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      a;
  logic [31:0]     d;
  logic            we;
  logic [31:0]     spo;
  logic [NSRC-1:0] src_irq;
  logic            irq_out;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .d       (d),
    .we      (we),
    .spo     (spo),
    .src_irq (src_irq),
    .irq_out (irq_out)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'b0, irq_out}, {31'b0, exp});
  endtask

  // Driver tasks: called at a falling edge, return at the next falling edge.
  task automatic mmio_wr(input logic [2:0] addr, input logic [31:0] field);
    a  = addr;
    d  = swap32(field);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    d  = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] addr, input logic [31:0] field);
    a = addr;
    #1;
    check(tag, spo, swap32(field));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; a = '0; d = '0; we = 1'b0; src_irq = '0;
    @(negedge clk);
    chk_irq("rst_irq", 1'b0);
    rd("rst_pend", R_PEND, 32'h0);
    rd("rst_ena", R_ENA, 32'h0);
    rd("rst_sts", R_STS, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single pulse, pending at edge k, irq_out at k+1
    mmio_wr(R_ENA, 32'h1);
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = '0;
    a = R_PEND; #1;
    check("t1_pend_raw", spo, 32'h01000000);
    chk_irq("t1_irq_k", 1'b0);
    @(negedge clk);
    chk_irq("t1_irq_k1", 1'b1);
    rd("t1_claim", R_CLM, 32'h1);

    // 2: claim then complete
    mmio_wr(R_CLM, 32'h1);
    chk_irq("t2_irq_claim", 1'b0);
    rd("t2_sts_svc", R_STS, 32'h0101);
    rd("t2_pend", R_PEND, 32'h0);
    mmio_wr(R_CMP, 32'h1);
    rd("t2_sts_idle", R_STS, 32'h0);
    chk_irq("t2_irq_done", 1'b0);

    // 3: priority, RO/unmapped writes, upper field bits
    mmio_wr(R_ENA, 32'hFFFF_FFFF);
    rd("t3_ena", R_ENA, 32'hFF);
    mmio_wr(R_PEND, 32'hFF);
    rd("t3_pend_ro", R_PEND, 32'h0);
    mmio_wr(R_UNM, 32'hFF);
    rd("t3_unmapped", R_UNM, 32'h0);
    src_irq = 8'h24;
    @(negedge clk);
    src_irq = '0;
    @(negedge clk);
    chk_irq("t3_irq", 1'b1);
    rd("t3_claim3", R_CLM, 32'h3);
    rd("t3_pend24", R_PEND, 32'h24);
    mmio_wr(R_CLM, 32'h6);
    rd("t3_badclaim_sts", R_STS, 32'h0);
    chk_irq("t3_badclaim_irq", 1'b1);
    mmio_wr(R_CLM, 32'h3);
    rd("t3_sts3", R_STS, 32'h0301);
    rd("t3_pend20", R_PEND, 32'h20);
    chk_irq("t3_irq_svc", 1'b0);
    mmio_wr(R_CLM, 32'h6);
    rd("t3_svcclaim_sts", R_STS, 32'h0301);
    rd("t3_svcclaim_pend", R_PEND, 32'h20);
    mmio_wr(R_CMP, 32'h3);
    rd("t3_claim6", R_CLM, 32'h6);
    rd("t3_sts_idle", R_STS, 32'h0);
    @(negedge clk);
    chk_irq("t3_irq_again", 1'b1);
    mmio_wr(R_CLM, 32'h6);
    mmio_wr(R_CMP, 32'h6);
    rd("t3_claim0", R_CLM, 32'h0);
    @(negedge clk);
    chk_irq("t3_irq_off", 1'b0);

    // 4: edge set on the claim edge wins over the claim clear
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = '0;
    @(negedge clk);
    chk_irq("t4_irq", 1'b1);
    a = R_CLM; d = swap32(32'h1); we = 1'b1; src_irq = 8'h01;
    @(negedge clk);
    we = 1'b0; d = '0; src_irq = '0;
    rd("t4_pend_kept", R_PEND, 32'h1);
    rd("t4_sts", R_STS, 32'h0101);
    chk_irq("t4_irq_svc", 1'b0);
    mmio_wr(R_CMP, 32'h1);
    chk_irq("t4_irq_cmp_edge", 1'b0);
    @(negedge clk);
    chk_irq("t4_irq_reassert", 1'b1);
    mmio_wr(R_CLM, 32'h1);
    mmio_wr(R_CMP, 32'h1);
    rd("t4_pend_clean", R_PEND, 32'h0);

    // 5: level source, wrong complete, enable masking
    mmio_wr(R_MOD, 32'h2);
    rd("t5_mode", R_MOD, 32'h2);
    src_irq = 8'h02;
    cycles(2);
    chk_irq("t5_irq", 1'b1);
    rd("t5_claim2", R_CLM, 32'h2);
    mmio_wr(R_CLM, 32'h2);
    rd("t5_pend_level", R_PEND, 32'h2);
    rd("t5_sts", R_STS, 32'h0201);
    mmio_wr(R_CMP, 32'h5);
    rd("t5_badcmp_sts", R_STS, 32'h0201);
    chk_irq("t5_badcmp_irq", 1'b0);
    mmio_wr(R_CMP, 32'h2);
    rd("t5_sts_idle", R_STS, 32'h0);
    @(negedge clk);
    chk_irq("t5_irq_repend", 1'b1);
    mmio_wr(R_ENA, 32'h0);
    rd("t5_claim_masked", R_CLM, 32'h0);
    rd("t5_pend_masked", R_PEND, 32'h2);
    @(negedge clk);
    chk_irq("t5_irq_masked", 1'b0);
    mmio_wr(R_ENA, 32'hFF);
    @(negedge clk);
    chk_irq("t5_irq_unmask", 1'b1);
    mmio_wr(R_CLM, 32'h2);
    rd("t5_sts_svc2", R_STS, 32'h0201);

    // 6: asynchronous reset mid-SERVICE, away from any clock edge
    #2;
    src_irq = '0;
    rst = 1'b1;
    #1;
    chk_irq("t6_irq_async", 1'b0);
    rd("t6_pend", R_PEND, 32'h0);
    rd("t6_sts", R_STS, 32'h0);
    rd("t6_ena", R_ENA, 32'h0);
    rd("t6_mode", R_MOD, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mmio_wr(R_ENA, 32'h1);
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = '0;
    rd("t6_pend_k", R_PEND, 32'h1);
    chk_irq("t6_irq_k", 1'b0);
    @(negedge clk);
    chk_irq("t6_irq_k1", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
